// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// byte count and natural-alignment test.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    SPLIT  = 2'b10,
    RESP   = 2'b11
  } state_e;

  function automatic logic [3:0] nbytes(input size_e size);
    return 4'd1 << size;
  endfunction

  // Only the low three address bits matter for sizes up to eight bytes.
  function automatic logic is_aligned(input logic [2:0] addr_lo, input size_e size);
    return ({1'b0, addr_lo} & (nbytes(size) - 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load extension: keeps the low nbytes(size) bytes of data_in and
// sign- or zero-fills the rest; doubles pass through unchanged.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  size_e                 size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (size)
      SZ_BYTE:   data_out = {{(DATA_WIDTH-8){~is_unsigned & data_in[7]}},   data_in[7:0]};
      SZ_HALF:   data_out = {{(DATA_WIDTH-16){~is_unsigned & data_in[15]}}, data_in[15:0]};
      SZ_WORD:   data_out = {{(DATA_WIDTH-32){~is_unsigned & data_in[31]}}, data_in[31:0]};
      default:   data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: accept->rsp_valid is 2 cycles aligned, nbytes+1 split, 1 on error; rsp held until rsp_ready.
// LSU_MISALIGN_SPLIT_EN builds the byte-split path; otherwise misaligned requests return an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_memorywrite,
  output logic                     mem_memoryread,
  output logic [1:0]               mem_select,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  input  logic                     mem_unalign
);

  localparam logic [ADDRESS_WIDTH:0] MEM_BYTES = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  size_e                    size_q, size_d;
  logic                     uns_q, uns_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]               mem_sel_q, mem_sel_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]    ext_in, ext_out;
  logic                     range_err, aligned;

  assign range_err = ({1'b0, req_addr} + (ADDRESS_WIDTH+1)'(nbytes(size_e'(req_size)))) > MEM_BYTES;
  assign aligned   = is_aligned(req_addr[2:0], size_e'(req_size));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    asm_q, asm_d, asm_next;

  // Assembly with the byte returned this cycle merged in; the last byte is extended directly.
  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = mem_read_data[7:0];
  end
  assign ext_in = (state_q == SPLIT) ? asm_next : mem_read_data;
`else
  assign ext_in = mem_read_data;
`endif

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .data_in     (ext_in),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data_out    (ext_out)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_sel_d   = 2'b00;
    mem_wdata_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        we_d        = req_we;
        size_d      = size_e'(req_size);
        uns_d       = req_unsigned;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (range_err) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (aligned) begin
          state_d     = ACCESS;
          mem_addr_d  = req_addr;
          mem_sel_d   = req_size;
          mem_wdata_d = req_wdata;
          mem_rd_d    = ~req_we;
          mem_wr_d    = req_we;
        end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d     = SPLIT;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = 3'd0;
          asm_d       = '0;
          mem_addr_d  = req_addr;
          mem_wdata_d = DATA_WIDTH'(req_wdata[7:0]);
          mem_rd_d    = ~req_we;
          mem_wr_d    = req_we;
`else
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
`endif
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = mem_unalign;
        rsp_rdata_d = (we_q || mem_unalign) ? '0 : ext_out;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT: begin
        if ({1'b0, cnt_q} == nbytes(size_q) - 4'd1) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : ext_out;
        end else begin
          cnt_d       = cnt_q + 3'd1;
          asm_d       = asm_next;
          mem_addr_d  = addr_q + ADDRESS_WIDTH'(cnt_d);
          mem_wdata_d = DATA_WIDTH'(wdata_q[{cnt_d, 3'b000} +: 8]);
          mem_rd_d    = ~we_q;
          mem_wr_d    = we_q;
        end
      end
`endif
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= 2'b00;
      mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 3'd0;
      asm_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
`endif
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign mem_memoryread  = mem_rd_q;
  assign mem_memorywrite = mem_wr_q;
  assign mem_address     = mem_addr_q;
  assign mem_select      = mem_sel_q;
  assign mem_write_data  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, request-level reference model
// checked every cycle, plus hand-computed expectations for directed vectors.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, preload, force_unalign;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic [5:0]  mem_address;
  logic [63:0] mem_write_data, mem_read_data;
  logic        mem_memorywrite, mem_memoryread, mem_unalign;
  logic [1:0]  mem_select;

  logic [7:0]  mem [64];
  logic [7:0]  ref_mem [64];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(64), .ADDRESS_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memorywrite(mem_memorywrite), .mem_memoryread(mem_memoryread),
    .mem_select(mem_select), .mem_read_data(mem_read_data), .mem_unalign(mem_unalign)
  );

  function automatic logic [7:0] pat(input int i);
    return (i == 8) ? 8'h80 : (8'(i) ^ 8'hA5);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // data_memory stand-in: combinational read of 8 bytes from the address, sized writes.
  always_comb begin
    mem_read_data = '0;
    for (int b = 0; b < 8; b++) mem_read_data[8*b +: 8] = mem[6'(mem_address + 6'(b))];
  end
  assign mem_unalign = force_unalign ||
    ((mem_memoryread || mem_memorywrite) && ((mem_address & ((6'd1 << mem_select) - 6'd1)) != 6'd0));

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (mem_memorywrite) begin
      for (int b = 0; b < 8; b++)
        if (b < (1 << mem_select)) mem[6'(mem_address + 6'(b))] <= mem_write_data[8*b +: 8];
    end
  end

  function automatic logic [63:0] extend(input logic [63:0] v, input int nb, input bit uns);
    logic [63:0] mask;
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*nb)) - 64'd1);
    extend = v & mask;
    if (!uns && nb < 8 && v[8*nb-1]) extend = extend | ~mask;
  endfunction

  // Request-level model and per-cycle compare.
  bit          busy = 1'b0;
  int          k, exp_lat, exp_wr, exp_rd, nwr, nrd, last_nwr;
  logic [63:0] exp_rdata;
  logic        exp_err;
  logic [1:0]  sel_seen;

  always @(negedge clk) begin
    if (preload) for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      check("req_ready", req_ready, !busy);
      check("strobe_excl", mem_memoryread & mem_memorywrite, 0);
      if (!busy) begin
        check("idle_strobe", {mem_memoryread, mem_memorywrite}, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        if (req_valid) begin
          int nb, a;
          logic [63:0] v;
          bit al, nacc;
          nb = 1 << req_size;
          a = int'(req_addr);
          al = (a % nb) == 0;
          busy = 1'b1; k = 0; nwr = 0; nrd = 0;
          exp_rdata = '0; exp_err = 1'b0; exp_wr = 0; exp_rd = 0;
          if (a + nb > 64 || (!al && !SPLIT_EN)) begin
            exp_err = 1'b1; exp_lat = 1;
          end else begin
            exp_lat = al ? 2 : nb + 1;
            if (al && force_unalign) exp_err = 1'b1;
            if (req_we) begin
              exp_wr = al ? 1 : nb;
              if (!exp_err) for (int b = 0; b < nb; b++) ref_mem[a+b] = req_wdata[8*b +: 8];
            end else begin
              exp_rd = al ? 1 : nb;
              v = '0;
              for (int b = 0; b < nb; b++) v[8*b +: 8] = ref_mem[a+b];
              if (!exp_err) exp_rdata = extend(v, nb, req_unsigned);
            end
          end
        end
      end else begin
        k++;
        if (mem_memorywrite) nwr++;
        if (mem_memoryread) nrd++;
        if (mem_memorywrite || mem_memoryread) sel_seen = mem_select;
        if (k < exp_lat) begin
          check("rsp_early", rsp_valid, 0);
        end else begin
          check("rsp_valid", rsp_valid, 1);
          check("rsp_rdata", rsp_rdata, exp_rdata);
          check("rsp_err", rsp_err, exp_err);
          if (rsp_ready) begin
            int diff;
            diff = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff++;
            check("write_count", nwr, exp_wr);
            check("read_count", nrd, exp_rd);
            check("mem_image_diff", diff, 0);
            last_nwr = nwr;
            busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic run(input string name, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [5:0] addr, input logic [63:0] wd, input int stall, input logic fu,
                     input logic [63:0] x_rd, input logic x_err, input int x_lat);
    int n, lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; force_unalign = fu; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({name, "_accept_timeout"}, n >= 50, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; lat++; n++; end
    check({name, "_rsp_timeout"}, n >= 50, 0);
    repeat (stall) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    check({name, "_data"}, rsp_rdata, x_rd);
    check({name, "_err"}, rsp_err, x_err);
    check({name, "_latency"}, lat, x_lat);
    @(posedge clk); #1;
    rsp_ready = 1'b0; force_unalign = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; preload = 1'b1; force_unalign = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", req_ready, 1);
    check("reset_ctrl", {rsp_valid, rsp_err, mem_memoryread, mem_memorywrite, mem_select}, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_mem_bus", {mem_address, mem_write_data}, 0);
    preload = 1'b0;
    rst_n = 1'b1;

    run("ld_b_s",  0, 2'b00, 0, 6'd8,  64'h0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 2);
    run("ld_b_u",  0, 2'b00, 1, 6'd8,  64'h0, 0, 0, 64'h80, 0, 2);
    run("st_d",    1, 2'b11, 0, 6'd16, 64'h1122_3344_5566_7788, 0, 0, 64'h0, 0, 2);
    run("ld_d",    0, 2'b11, 0, 6'd16, 64'h0, 0, 0, 64'h1122_3344_5566_7788, 0, 2);
    check("ld_d_select", sel_seen, 2'b11);
    run("st_w_split", 1, 2'b10, 0, 6'd3, 64'hFFFF_0000_DEAD_BEEF, 0, 0, 64'h0, !SPLIT_EN, SPLIT_EN ? 5 : 1);
    check("st_w_split_writes", last_nwr, SPLIT_EN ? 4 : 0);
    check("st_w_split_bytes", {mem[6], mem[5], mem[4], mem[3]}, SPLIT_EN ? 32'hDEAD_BEEF : 32'hA3A0_A1A6);
    run("ld_w_split", 0, 2'b10, 0, 6'd3, 64'h0, 0, 0,
        SPLIT_EN ? 64'hFFFF_FFFF_DEAD_BEEF : 64'h0, !SPLIT_EN, SPLIT_EN ? 5 : 1);
    run("ld_h_mis", 0, 2'b01, 0, 6'd1, 64'h0, 0, 0,
        SPLIT_EN ? 64'hFFFF_FFFF_FFFF_A7A4 : 64'h0, !SPLIT_EN, SPLIT_EN ? 3 : 1);
    run("st_d_range", 1, 2'b11, 0, 6'd60, 64'hCAFE_F00D_1234_5678, 0, 0, 64'h0, 1, 1);
    check("st_d_range_mem", {mem[63], mem[62], mem[61], mem[60]}, 32'h9A9B_9899);
    run("ld_b_top", 0, 2'b00, 1, 6'd63, 64'h0, 0, 0, 64'h9A, 0, 2);
    run("ld_h_top", 0, 2'b01, 1, 6'd62, 64'h0, 0, 0, 64'h9A9B, 0, 2);
    run("ld_h_range", 0, 2'b01, 0, 6'd63, 64'h0, 0, 0, 64'h0, 1, 1);
    run("ld_d_stall", 0, 2'b11, 0, 6'd16, 64'h0, 5, 0, 64'h1122_3344_5566_7788, 0, 2);
    run("ld_w_unalign", 0, 2'b10, 0, 6'd8, 64'h0, 0, 1, 64'h0, 1, 2);
    run("st_h", 1, 2'b01, 0, 6'd32, 64'h0000_0000_0000_8001, 0, 0, 64'h0, 0, 2);
    run("ld_h_s", 0, 2'b01, 0, 6'd32, 64'h0, 0, 0, 64'hFFFF_FFFF_FFFF_8001, 0, 2);

    // Reset in the middle of a request: split load when built, else stalled response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = SPLIT_EN ? 6'd1 : 6'd16; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_op_busy", req_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_ctrl", {rsp_valid, rsp_err, mem_memoryread, mem_memorywrite, mem_select}, 0);
    check("rst_mid_rdata", rsp_rdata, 0);
    check("rst_mid_mem_bus", {mem_address, mem_write_data}, 0);
    rst_n = 1'b1;
    run("ld_after_rst", 0, 2'b00, 1, 6'd8, 64'h0, 0, 0, 64'h80, 0, 2);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
